branch_update_queue: RTL and testbench

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/lc3b_types.sv | 15 +
 rtl/branch_update_queue_if.sv | 46 ++++
 rtl/branch_update_fifo.sv | 71 +++++++
 rtl/branch_update_queue.sv | 125 ++++++++++++
 tb/tb_branch_update_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared predictor widths and the in-flight branch entry layout
package lc3b_types;

  localparam int LC3B_LS = 8;
  localparam int LC3B_GS = 6;

  // Field order matches the flat word the queue stores, MSB first.
  typedef struct packed {
    logic [LC3B_LS-1:0] l_index;
    logic [LC3B_GS-1:0] g_index;
    logic [1:0]         pred;
    logic               taken;
  } buq_entry_t;

endpackage

// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - fetch/execute side bundle of the branch update queue
interface branch_update_queue_if
  import lc3b_types::*;
#(
  parameter int ls    = LC3B_LS,
  parameter int gs    = LC3B_GS,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push;
  logic [ls-1:0] push_l_index;
  logic [gs-1:0] push_g_index;
  logic [1:0]    push_pred;
  logic          push_taken;
  logic          resolve;
  logic          resolve_taken;
  logic          flush;

  logic          update;
  logic          result;
  logic [ls-1:0] lup_index;
  logic [gs-1:0] gup_index;
  logic [1:0]    pred_out;
  logic          mispredict;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [15:0]   stat_resolved;
  logic [15:0]   stat_mispred;

  modport master (
    output push, push_l_index, push_g_index, push_pred, push_taken,
    output resolve, resolve_taken, flush,
    input  update, result, lup_index, gup_index, pred_out, mispredict,
    input  full, empty, count, stat_resolved, stat_mispred
  );

  modport slave (
    input  push, push_l_index, push_g_index, push_pred, push_taken,
    input  resolve, resolve_taken, flush,
    output update, result, lup_index, gup_index, pred_out, mispredict,
    output full, empty, count, stat_resolved, stat_mispred
  );

endinterface

// File: rtl/branch_update_fifo.sv
// rtl/branch_update_fifo.sv - program-order storage for in-flight branch entries
module branch_update_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_req,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_req,
  input  logic                       flush,
  output logic [W-1:0]               rd_data,
  output logic                       rd_ok,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full queue still takes a push when the head retires in the same cycle.
  assign rd_ok = rd_req && !empty;
  assign wr_ok = wr_req && !flush && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - branch predictor training queue; BUQ_STATS_EN adds resolve/mispredict counters
module branch_update_queue
  import lc3b_types::*;
#(
  parameter int ls    = LC3B_LS,
  parameter int gs    = LC3B_GS,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_update_queue_if.slave bus
);
  localparam int W = ls + gs + 3;

  logic [W-1:0]  wr_data;
  logic [W-1:0]  head;
  logic          rd_ok;
  logic [ls-1:0] head_l;
  logic [gs-1:0] head_g;
  logic [1:0]    head_pred;
  logic          head_taken;
  logic          mispred_now;

  assign wr_data = {bus.push_l_index, bus.push_g_index, bus.push_pred, bus.push_taken};

  branch_update_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_req  (bus.push),
    .wr_data (wr_data),
    .rd_req  (bus.resolve),
    .flush   (bus.flush),
    .rd_data (head),
    .rd_ok   (rd_ok),
    .count   (bus.count),
    .full    (bus.full),
    .empty   (bus.empty)
  );

  assign head_l      = head[W-1 -: ls];
  assign head_g      = head[gs+2:3];
  assign head_pred   = head[2:1];
  assign head_taken  = head[0];
  assign mispred_now = rd_ok && (bus.resolve_taken ^ head_taken);

  logic          update_q, update_d;
  logic          result_q, result_d;
  logic [ls-1:0] lup_q, lup_d;
  logic [gs-1:0] gup_q, gup_d;
  logic [1:0]    pred_q, pred_d;
  logic          mispredict_q, mispredict_d;

  // A flush does not stop the head from retiring, so training keys only on rd_ok.
  always_comb begin
    update_d     = rd_ok;
    mispredict_d = mispred_now;
    result_d     = result_q;
    lup_d        = lup_q;
    gup_d        = gup_q;
    pred_d       = pred_q;
    if (rd_ok) begin
      result_d = bus.resolve_taken;
      lup_d    = head_l;
      gup_d    = head_g;
      pred_d   = head_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      update_q     <= 1'b0;
      result_q     <= 1'b0;
      lup_q        <= '0;
      gup_q        <= '0;
      pred_q       <= '0;
      mispredict_q <= 1'b0;
    end else begin
      update_q     <= update_d;
      result_q     <= result_d;
      lup_q        <= lup_d;
      gup_q        <= gup_d;
      pred_q       <= pred_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign bus.update     = update_q;
  assign bus.result     = result_q;
  assign bus.lup_index  = lup_q;
  assign bus.gup_index  = gup_q;
  assign bus.pred_out   = pred_q;
  assign bus.mispredict = mispredict_q;

`ifdef BUQ_STATS_EN
  logic [15:0] stat_resolved_q, stat_resolved_d;
  logic [15:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (rd_ok && stat_resolved_q != 16'hFFFF) stat_resolved_d = stat_resolved_q + 16'd1;
    if (mispred_now && stat_mispred_q != 16'hFFFF) stat_mispred_d = stat_mispred_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign bus.stat_resolved = stat_resolved_q;
  assign bus.stat_mispred  = stat_mispred_q;
`else
  assign bus.stat_resolved = 16'h0000;
  assign bus.stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - directed bench with a queue-level reference model
module tb_branch_update_queue;
  import lc3b_types::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_update_queue_if #(.ls(8), .gs(6), .DEPTH(DEPTH)) bus ();

  branch_update_queue #(.ls(8), .gs(6), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  buq_entry_t mq[$];
  logic       exp_update, exp_result, exp_mis;
  logic [7:0] exp_lup;
  logic [5:0] exp_gup;
  logic [1:0] exp_pred;
  int         exp_sr, exp_sm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    bit         res_ok;
    bit         push_ok;
    buq_entry_t h;
    buq_entry_t e;
    if (!rst_n) begin
      mq.delete();
      exp_update = 0; exp_result = 0; exp_mis = 0;
      exp_lup = 0; exp_gup = 0; exp_pred = 0;
      exp_sr = 0; exp_sm = 0;
      return;
    end
    res_ok     = bus.resolve && (mq.size() > 0);
    exp_update = res_ok;
    exp_mis    = 0;
    if (res_ok) begin
      h          = mq.pop_front();
      exp_result = bus.resolve_taken;
      exp_lup    = h.l_index;
      exp_gup    = h.g_index;
      exp_pred   = h.pred;
      exp_mis    = (bus.resolve_taken != h.taken);
      if (exp_sr < 65535) exp_sr++;
      if (exp_mis && exp_sm < 65535) exp_sm++;
    end
    push_ok = bus.push && !bus.flush && (mq.size() < DEPTH);
    if (bus.flush) begin
      mq.delete();
    end else if (push_ok) begin
      e.l_index = bus.push_l_index;
      e.g_index = bus.push_g_index;
      e.pred    = bus.push_pred;
      e.taken   = bus.push_taken;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    int sr_req;
    int sm_req;
`ifdef BUQ_STATS_EN
    sr_req = exp_sr;
    sm_req = exp_sm;
`else
    sr_req = 0;
    sm_req = 0;
`endif
    check("update", 32'(bus.update), 32'(exp_update));
    check("mispredict", 32'(bus.mispredict), 32'(exp_mis));
    check("result", 32'(bus.result), 32'(exp_result));
    check("lup_index", 32'(bus.lup_index), 32'(exp_lup));
    check("gup_index", 32'(bus.gup_index), 32'(exp_gup));
    check("pred_out", 32'(bus.pred_out), 32'(exp_pred));
    check("count", 32'(bus.count), 32'(mq.size()));
    check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("stat_resolved", 32'(bus.stat_resolved), 32'(sr_req));
    check("stat_mispred", 32'(bus.stat_mispred), 32'(sm_req));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic p, input logic [7:0] l, input logic [5:0] g,
                       input logic [1:0] pr, input logic t, input logic r,
                       input logic rt, input logic f);
    bus.push          = p;
    bus.push_l_index  = l;
    bus.push_g_index  = g;
    bus.push_pred     = pr;
    bus.push_taken    = t;
    bus.resolve       = r;
    bus.resolve_taken = rt;
    bus.flush         = f;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 6'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] want40 [4] = '{8'h21, 8'h22, 8'h23, 8'h30};

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_full", 32'(bus.full), 32'd0);
    rst_n = 1'b1;
    idle();

    // Single push then mispredicted resolve.
    drive(1'b1, 8'h12, 6'h05, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 6'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("basic_update", 32'(bus.update), 32'd1);
    check("basic_lup", 32'(bus.lup_index), 32'h12);
    check("basic_gup", 32'(bus.gup_index), 32'h05);
    check("basic_pred", 32'(bus.pred_out), 32'h2);
    check("basic_result", 32'(bus.result), 32'd0);
    check("basic_mispredict", 32'(bus.mispredict), 32'd1);
    idle();
    check("basic_update_drop", 32'(bus.update), 32'd0);
    check("basic_lup_hold", 32'(bus.lup_index), 32'h12);

    // Fill, overflow, push+resolve at full.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 8'h20 + 8'(i), 6'(i), 2'(i), i[0], 1'b0, 1'b0, 1'b0);
    check("fill_full", 32'(bus.full), 32'd1);
    drive(1'b1, 8'hAA, 6'h3F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("overflow_count", 32'(bus.count), 32'd4);
    drive(1'b1, 8'h30, 6'h2A, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    check("full_pr_lup", 32'(bus.lup_index), 32'h20);
    check("full_pr_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 6'h00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      check("order_lup", 32'(bus.lup_index), 32'(want40[i]));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Resolve on empty queue.
    drive(1'b0, 8'h00, 6'h00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("empty_res_update", 32'(bus.update), 32'd0);
    check("empty_res_count", 32'(bus.count), 32'd0);

    // Flush with same-cycle resolve and push.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'h40 + 8'(i), 6'h11 + 6'(i), 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 6'h22, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("flush_update", 32'(bus.update), 32'd1);
    check("flush_lup", 32'(bus.lup_index), 32'h40);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    idle();

    // Pointer wrap with paired push/resolve.
    drive(1'b1, 8'h50, 6'h10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 8'h50 + 8'(i), 6'(i), 2'(i), i[0], 1'b1, ~i[0], 1'b0);
      check("wrap_lup", 32'(bus.lup_index), 32'h50 + 32'(i) - 32'd1);
      check("wrap_count", 32'(bus.count), 32'd1);
    end
    drive(1'b0, 8'h00, 6'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_last_lup", 32'(bus.lup_index), 32'h59);
    check("wrap_end_count", 32'(bus.count), 32'd0);

    // Reset mid-stream overrides push and resolve.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'h60 + 8'(i), 6'h01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'h6F, 6'h0F, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_update", 32'(bus.update), 32'd0);
    check("midrst_stat_res", 32'(bus.stat_resolved), 32'd0);
    check("midrst_stat_mis", 32'(bus.stat_mispred), 32'd0);
    rst_n = 1'b1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
